regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between NREQ writeback sources
//    (e.g. ALU, load unit, multiply/divide unit).
//  Each source offers (rd, data) on a valid/ready handshake.
//  The block grants one source per cycle, round-robin, and drives a registered
//    write command (reg_write, rd, write_data) into register_file.
//  Sits between the execute/memory stages and the register file write port.
// PARAMETERS
//  NREQ    3   number of writeback requesters, 2..8
//  XLEN    32  data width of a register
//  AW      5   register address width (32 architectural registers)
// PORTS
//  clk          in   1          rising-edge clock for all state
//  rst          in   1          asynchronous, active-high reset
//  req_valid    in   NREQ       requester i has a write pending
//  req_rd       in   NREQ*AW    dest reg of requester i, bits [i*AW +: AW]
//  req_data     in   NREQ*XLEN  write data of requester i, bits [i*XLEN +: XLEN]
//  req_ready    out  NREQ       one-hot grant; transfer when valid[i] & ready[i]
//  wb_hold      in   1          downstream stall: no grants while high
//  reg_write    out  1          write enable to register_file
//  rd           out  AW         write address to register_file
//  write_data   out  XLEN       write data to register_file
//  grant_id     out  3          index of the source written last cycle (debug/perf)
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//    ptr=0; reg_write=0; rd=0; write_data=0; grant_id=0.
//    req_ready is held 0 while rst is high.
//  Grant (combinational, same cycle as valid):
//    Scan indices ptr, ptr+1, ..., ptr+NREQ-1 mod NREQ.
//    The first i with req_valid[i] gets req_ready[i]=1; all other ready bits are 0.
//    If wb_hold=1 or no valid is high, all req_ready=0.
//    req_ready never depends on ready of another source; no comb loop through valid.
//  Pointer: on a transfer by source i, ptr <= (i+1) mod NREQ.
//    With no transfer, ptr holds.
//    Wrap: i=NREQ-1 gives ptr=0.
//  Write command (registered, latency 1): on the clock edge ending a transfer cycle:
//    rd <= req_rd[i]; write_data <= req_data[i]; grant_id <= i.
//    reg_write <= (req_rd[i] != 0).
//    Writes to x0 are accepted (handshake completes) but never assert reg_write.
//  Cycles with no transfer: reg_write <= 0; rd and write_data hold their last values.
//  Throughput: one write per cycle sustained; no bubbles between back-to-back grants.
//  Requester rule: once req_valid[i] is high, the source holds it and its rd/data
//    stable until the transfer. The arbiter does not check this.
//  Fairness: a continuously valid source is granted within NREQ transfers.
//  wb_hold rising mid-burst: the already-registered write still issues next cycle.
//    Grants then stop until wb_hold falls.
//  Reset mid-operation: a write registered but not yet seen by register_file is
//    discarded (reg_write forced 0). Sources must re-offer it.
//  Same rd from two sources: writes are serialized in grant order; the later grant wins.
// STRUCTURE
//  Shared package riscv_pkg:
//    XLEN, REG_AW, NUM_REGS.
//    WB_SRC_ALU=0, WB_SRC_LSU=1, WB_SRC_MDU=2 source indices.
//  Sub-module rr_arbiter: parameterized NREQ; inputs req, ptr, en; output one-hot grant.
//    Reusable by other shared resources.
//  Top holds ptr, the output register stage, the x0 suppression and the bus muxing.
// TESTING
//  1 Reset: rst=1 mid-stream with valid=3'b111
//    -> req_ready=0 and reg_write=0 asynchronously.
//    After release, the first grant goes to src0.
//  2 Single source: src1 valid, rd=7, data=32'hDEADBEEF
//    -> ready[1]=1 in the same cycle.
//    Next cycle reg_write=1, rd=7, write_data=32'hDEADBEEF, grant_id=1.
//  3 Round-robin: valid=3'b111 held 6 cycles
//    -> grant order 0,1,2,0,1,2; reg_write high 6 consecutive cycles.
//  4 x0 write: src2 rd=0, data=5
//    -> ready[2]=1; next cycle reg_write=0.
//    Register file x0 reads 0 afterwards.
//  5 Hold: valid=3'b011, wb_hold=1 for 3 cycles
//    -> ready=0 and reg_write=0 throughout; ptr unchanged.
//    After release, src (ptr) is granted first.
//  6 Ordering: src0 then src1 both target rd=5, data 10 then 20
//    -> x5 reads 20 after both writes complete.

Source files
------------

// File: rtl/riscv_pkg.sv
// Core-wide constants shared by the pipeline blocks: register file geometry
// and the writeback source indices used by the writeback arbiter.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    // Writeback port assignment on the arbiter's request vector.
    typedef enum logic [2:0] {
        WB_SRC_ALU = 3'd0,
        WB_SRC_LSU = 3'd1,
        WB_SRC_MDU = 3'd2
    } wb_src_e;

    localparam int WB_NREQ = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), one-hot, only while en is high.
module rr_arbiter #(
    parameter  int NREQ = 3,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan ptr, ptr+1, ... modulo NREQ; sum is one bit wider so the wrap
    // compare never overflows.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between NREQ writeback sources with a
// round-robin grant and a registered write command (latency 1).
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter int NREQ = WB_NREQ,
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int AW   = REG_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wb_hold,
    output logic                 reg_write,
    output logic [AW-1:0]        rd,
    output logic [XLEN-1:0]      write_data,
    output logic [2:0]           grant_id
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] grant;
    logic [2:0]      gnt_idx;
    logic            transfer;
    logic [AW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;

    // Grants are suppressed during reset so no source sees a phantom handshake.
    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (!wb_hold && !rst),
        .grant (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    always_comb begin
        gnt_idx  = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx  = 3'(i);
                sel_rd   = req_rd[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
        ptr_next = ptr;
        if (transfer) begin
            ptr_next = (int'(gnt_idx) == NREQ-1) ? '0 : PW'(gnt_idx + 3'd1);
        end
    end

    // x0 writes complete the handshake but never reach the register file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
            grant_id   <= '0;
        end else begin
            ptr <= ptr_next;
            if (transfer) begin
                reg_write  <= (sel_rd != '0);
                rd         <= sel_rd;
                write_data <= sel_data;
                grant_id   <= gnt_idx;
            end else begin
                reg_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle vector table with a
// write-command scoreboard, a register file model, and a mid-stream reset sequence.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_hold;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [2:0]  grant_id;

    typedef struct {
        logic [2:0]  valid;
        logic        hold;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  ready;
    } vec_t;

    typedef struct {
        logic        xfer;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  id;
    } exp_t;

    localparam int NVEC = 17;

    exp_t        sb[$];
    vec_t        vecs[NVEC];
    int          checks   = 0;
    int          failures = 0;
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    logic [31:0] rf[32];

    regfile_wb_arbiter #(.NREQ(3), .XLEN(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wb_hold    (wb_hold),
        .reg_write  (reg_write),
        .rd         (rd),
        .write_data (write_data),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_write) rf[rd] <= write_data;
    end

    function automatic vec_t mk(input logic [2:0] valid, input logic hold,
                                input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
                                input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                                input logic [2:0] ready);
        vec_t v;
        v.valid = valid;
        v.hold  = hold;
        v.rd    = {r2, r1, r0};
        v.data  = {d2, d1, d0};
        v.ready = ready;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkPending();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("reg_write", 32'(reg_write), 32'(e.we));
            checkOutput("rd", 32'(rd), 32'(e.rd));
            checkOutput("write_data", write_data, e.data);
            if (e.xfer) checkOutput("grant_id", 32'(grant_id), 32'(e.id));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int row);
        exp_t e;
        checkPending();
        req_valid = v.valid;
        wb_hold   = v.hold;
        req_rd    = v.rd;
        req_data  = v.data;
        #1;
        checkOutput($sformatf("req_ready row %0d", row), 32'(req_ready), 32'(v.ready));
        e.xfer = |v.ready;
        e.we   = 1'b0;
        e.rd   = last_rd;
        e.data = last_data;
        e.id   = '0;
        for (int i = 0; i < 3; i++) begin
            if (v.ready[i]) begin
                e.rd   = v.rd[i*5 +: 5];
                e.data = v.data[i*32 +: 32];
                e.we   = (e.rd != 5'd0);
                e.id   = 3'(i);
            end
        end
        last_rd   = e.rd;
        last_data = e.data;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 3'b111;
        wb_hold   = 1'b0;
        req_rd    = '0;
        req_data  = '0;
        last_rd   = '0;
        last_data = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;

        // Round-robin burst from reset, then single source, x0, hold, same-rd ordering.
        for (int r = 0; r < 6; r++) begin
            vecs[r] = mk(3'b111, 1'b0, 5'd3, 5'd2, 5'd1,
                         32'h300 + 32'(r), 32'h200 + 32'(r), 32'h100 + 32'(r),
                         3'(1 << (r % 3)));
        end
        vecs[6]  = mk(3'b010, 1'b0, 5'd0, 5'd7, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010);
        vecs[7]  = mk(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);
        vecs[8]  = mk(3'b100, 1'b0, 5'd0, 5'd0, 5'd0, 32'd5, 32'h0, 32'h0, 3'b100);
        vecs[9]  = mk(3'b011, 1'b1, 5'd0, 5'd10, 5'd9, 32'h0, 32'hAA, 32'h99, 3'b000);
        vecs[10] = mk(3'b011, 1'b1, 5'd0, 5'd10, 5'd9, 32'h0, 32'hAA, 32'h99, 3'b000);
        vecs[11] = mk(3'b011, 1'b1, 5'd0, 5'd10, 5'd9, 32'h0, 32'hAA, 32'h99, 3'b000);
        vecs[12] = mk(3'b011, 1'b0, 5'd0, 5'd10, 5'd9, 32'h0, 32'hAA, 32'h99, 3'b001);
        vecs[13] = mk(3'b010, 1'b0, 5'd0, 5'd10, 5'd0, 32'h0, 32'hAA, 32'h0, 3'b010);
        vecs[14] = mk(3'b001, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'd10, 3'b001);
        vecs[15] = mk(3'b010, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0, 32'd20, 32'h0, 3'b010);
        vecs[16] = mk(3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000);

        #12;
        checkOutput("reset req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset reg_write", 32'(reg_write), 32'h0);
        checkOutput("reset rd", 32'(rd), 32'h0);
        checkOutput("reset write_data", write_data, 32'h0);
        checkOutput("reset grant_id", 32'(grant_id), 32'h0);
        req_valid = 3'b000;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int r = 0; r < NVEC; r++) applyStimulus(vecs[r], r);
        checkPending();

        checkOutput("rf x0", rf[0], 32'h0);
        checkOutput("rf x5 later grant wins", rf[5], 32'd20);
        checkOutput("rf x7", rf[7], 32'hDEADBEEF);

        // Pointer is 2 here; register a write, then reset before it lands.
        req_valid = 3'b111;
        req_rd    = {5'd3, 5'd2, 5'd1};
        req_data  = {32'h333, 32'h222, 32'h111};
        #1;
        checkOutput("midrst ready before", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        checkOutput("midrst reg_write pending", 32'(reg_write), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst async ready", 32'(req_ready), 32'h0);
        checkOutput("midrst async reg_write", 32'(reg_write), 32'h0);
        checkOutput("midrst async rd", 32'(rd), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("post-reset first grant", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        checkOutput("post-reset reg_write", 32'(reg_write), 32'h1);
        checkOutput("post-reset rd", 32'(rd), 32'd1);
        checkOutput("post-reset write_data", write_data, 32'h111);
        checkOutput("post-reset grant_id", 32'(grant_id), 32'h0);
        req_valid = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
